// File: rtl/portal_mmio_bridge.sv
// Register-bus slave that maps single-beat host writes/reads onto the portal
// request-enqueue and indication-dequeue handshakes, with interrupt masking.
module portal_mmio_bridge #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  input  logic              rsp_ready,
  output logic [1:0]        selectRequest,
  output logic [31:0]       requestEnqV,
  output logic              EN_request,
  input  logic              RDY_requestEnq,
  output logic [1:0]        selectIndication,
  output logic              EN_indication,
  input  logic              RDY_indication,
  input  logic              indicationNotEmpty,
  input  logic [31:0]       indicationData,
  input  logic [31:0]       indIntrChannel,
  output logic              intr
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_EVAL, RSP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             intr_en;
  logic             err;
  logic             en_req_q;
  logic             rd_ind;
  logic [1:0]       rd_reg;
  logic             pop;
  logic [31:0]      rd_word;
  logic             unused_addr;

  assign unused_addr = ^{wr_addr, rd_addr};

  // Strobes are gated by RST so nothing reaches the portal during the reset cycle.
  assign wr_ready      = !RST && (state == IDLE) && wr_valid;
  assign rd_ready      = !RST && (state == IDLE) && !wr_valid && rd_valid;
  assign EN_request    = !RST && en_req_q;
  assign pop           = (state == RD_EVAL) && rd_ind && (rd_reg == 2'd0)
                         && indicationNotEmpty && RDY_indication;
  assign EN_indication = !RST && pop;

  always_comb begin
    rd_word = '0;
    if (!rd_ind) begin
      rd_word = {31'b0, RDY_requestEnq};
    end else begin
      case (rd_reg)
        2'd0:    rd_word = (indicationNotEmpty && RDY_indication) ? indicationData : '0;
        2'd1:    rd_word = {31'b0, indicationNotEmpty};
        2'd2:    rd_word = {30'b0, err, intr_en};
        default: rd_word = indIntrChannel;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      cnt              <= '0;
      intr_en          <= 1'b0;
      err              <= 1'b0;
      en_req_q         <= 1'b0;
      rd_ind           <= 1'b0;
      rd_reg           <= '0;
      selectRequest    <= '0;
      requestEnqV      <= '0;
      selectIndication <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      intr             <= 1'b0;
    end else begin
      en_req_q <= 1'b0;
      intr     <= intr_en && (indIntrChannel != '0);
      case (state)
        IDLE: begin
          if (wr_valid) begin
            if (!wr_addr[15]) begin
              selectRequest <= wr_addr[5:4];
              requestEnqV   <= wr_data;
              cnt           <= '0;
              state         <= WR_WAIT;
            end else if (wr_addr[3:2] == 2'd2) begin
              intr_en <= wr_data[0];
              if (wr_data[1]) err <= 1'b0;
            end
          end else if (rd_valid) begin
            rd_ind <= rd_addr[15];
            rd_reg <= rd_addr[3:2];
            if (rd_addr[15]) selectIndication <= rd_addr[5:4];
            state <= RD_EVAL;
          end
        end
        WR_WAIT: begin
          if (RDY_requestEnq) begin
            en_req_q <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            // The write is dropped after TIMEOUT cycles of RDY held low.
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        RD_EVAL: begin
          rsp_data  <= rd_word;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_portal_mmio_bridge.sv
// Directed-vector bench for portal_mmio_bridge with hand-computed expectations.
module tb_portal_mmio_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wr_valid, rd_valid, rsp_ready;
  logic [15:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic        wr_ready, rd_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  selectRequest, selectIndication;
  logic [31:0] requestEnqV;
  logic        EN_request, RDY_requestEnq;
  logic        EN_indication, RDY_indication, indicationNotEmpty;
  logic [31:0] indicationData, indIntrChannel;
  logic        intr;

  int vectors = 0;
  int miscompares = 0;
  int en_req_cnt = 0;
  int en_ind_cnt = 0;

  always #5 CLK = ~CLK;

  portal_mmio_bridge #(.ADDR_W(16), .TIMEOUT(255), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .selectRequest(selectRequest), .requestEnqV(requestEnqV), .EN_request(EN_request),
    .RDY_requestEnq(RDY_requestEnq),
    .selectIndication(selectIndication), .EN_indication(EN_indication),
    .RDY_indication(RDY_indication), .indicationNotEmpty(indicationNotEmpty),
    .indicationData(indicationData), .indIntrChannel(indIntrChannel), .intr(intr)
  );

  always @(posedge CLK) begin
    if (EN_request) en_req_cnt++;
    if (EN_indication) en_ind_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Returns one cycle after the accepting edge, with wr_valid dropped.
  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_ready && n < 400) begin step(); n++; end
    if (!wr_ready) check("wr_accept_timeout", 32'd0, 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] a, output logic [31:0] d);
    int n;
    n = 0;
    rd_valid = 1'b1; rd_addr = a;
    #1;
    while (!rd_ready && n < 400) begin step(); n++; end
    if (!rd_ready) check("rd_accept_timeout", 32'd0, 32'd1);
    step();
    rd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    d = rsp_data;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd0);
    check({tag, "_rd_ready"}, {31'b0, rd_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_sel_req"}, {30'b0, selectRequest}, 32'd0);
    check({tag, "_enq_v"}, requestEnqV, 32'd0);
    check({tag, "_en_req"}, {31'b0, EN_request}, 32'd0);
    check({tag, "_sel_ind"}, {30'b0, selectIndication}, 32'd0);
    check({tag, "_en_ind"}, {31'b0, EN_indication}, 32'd0);
    check({tag, "_intr"}, {31'b0, intr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int base;
    RST = 1'b1; wr_valid = 0; rd_valid = 0; rsp_ready = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    RDY_requestEnq = 0; RDY_indication = 0; indicationNotEmpty = 0;
    indicationData = '0; indIntrChannel = '0;
    repeat (3) step();
    check_all_zero("reset");
    RST = 1'b0;
    step();

    // 1: request-window write with RDY high
    RDY_requestEnq = 1'b1;
    base = en_req_cnt;
    host_write(16'h0010, 32'hCAFEF00D);
    check("t1_sel_req", {30'b0, selectRequest}, 32'd1);
    check("t1_en_early", {31'b0, EN_request}, 32'd0);
    step();
    check("t1_en_pulse", {31'b0, EN_request}, 32'd1);
    check("t1_enq_v", requestEnqV, 32'hCAFEF00D);
    step();
    check("t1_en_end", {31'b0, EN_request}, 32'd0);
    check("t1_en_count", en_req_cnt - base, 32'd1);

    // 2: timeout sets err, W1C clears it; late RDY just inside the window still enqueues
    RDY_requestEnq = 1'b0;
    base = en_req_cnt;
    host_write(16'h0020, 32'h00000011);
    check("t2_sel_req", {30'b0, selectRequest}, 32'd2);
    repeat (300) step();
    check("t2_no_en", en_req_cnt - base, 32'd0);
    host_read(16'h8008, d);
    check("t2_ctrl_err", d, 32'h2);
    host_write(16'h8008, 32'h2);
    host_read(16'h8008, d);
    check("t2_ctrl_clr", d, 32'h0);
    host_write(16'h0000, 32'h00000055);
    repeat (250) step();
    RDY_requestEnq = 1'b1;
    step();
    check("t2_late_rdy_en", {31'b0, EN_request}, 32'd1);
    host_read(16'h8008, d);
    check("t2_late_rdy_noerr", d, 32'h0);

    // 3: indication reads
    indicationNotEmpty = 1'b1; RDY_indication = 1'b1; indicationData = 32'h12345678;
    base = en_ind_cnt;
    host_read(16'h8024, d);
    check("t3_status", d, 32'h1);
    check("t3_sel_ind2", {30'b0, selectIndication}, 32'd2);
    check("t3_status_nopop", en_ind_cnt - base, 32'd0);
    host_read(16'h8000, d);
    check("t3_data", d, 32'h12345678);
    check("t3_sel_ind0", {30'b0, selectIndication}, 32'd0);
    check("t3_pop_count", en_ind_cnt - base, 32'd1);
    indicationNotEmpty = 1'b0;
    host_read(16'h8000, d);
    check("t3_empty_data", d, 32'h0);
    check("t3_empty_nopop", en_ind_cnt - base, 32'd1);
    indicationNotEmpty = 1'b1; RDY_indication = 1'b0;
    host_read(16'h8000, d);
    check("t3_nrdy_data", d, 32'h0);
    check("t3_nrdy_nopop", en_ind_cnt - base, 32'd1);
    RDY_requestEnq = 1'b1;
    host_read(16'h0010, d);
    check("t3_req_rdy", d, 32'h1);

    // 4: simultaneous write and read; held response
    indIntrChannel = 32'd7;
    wr_valid = 1'b1; wr_addr = 16'h0030; wr_data = 32'hA5A50001;
    rd_valid = 1'b1; rd_addr = 16'h800C;
    #1;
    check("t4_wr_first", {31'b0, wr_ready}, 32'd1);
    check("t4_rd_held", {31'b0, rd_ready}, 32'd0);
    step();
    wr_valid = 1'b0;
    #1;
    check("t4_rd_blocked", {31'b0, rd_ready}, 32'd0);
    check("t4_sel_req", {30'b0, selectRequest}, 32'd3);
    step();
    check("t4_en_req", {31'b0, EN_request}, 32'd1);
    check("t4_rd_accept", {31'b0, rd_ready}, 32'd1);
    step();
    rd_valid = 1'b0;
    step();
    indIntrChannel = 32'd0;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("t4_hold_data", rsp_data, 32'd7);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    check("t4_rsp_done", {31'b0, rsp_valid}, 32'd0);

    // 5: interrupt masking and latency
    indIntrChannel = 32'd3;
    step(); step();
    check("t5_masked", {31'b0, intr}, 32'd0);
    host_write(16'h8008, 32'h1);
    check("t5_latency", {31'b0, intr}, 32'd0);
    step();
    check("t5_intr_on", {31'b0, intr}, 32'd1);
    indIntrChannel = 32'd0;
    step();
    check("t5_intr_off", {31'b0, intr}, 32'd0);
    host_read(16'h8008, d);
    check("t5_ctrl", d, 32'h1);

    // 6: reset during WR_WAIT
    indIntrChannel = 32'd5;
    step(); step();
    check("t6_intr_pre", {31'b0, intr}, 32'd1);
    RDY_requestEnq = 1'b0;
    host_write(16'h0020, 32'hDEAD0001);
    step(); step();
    base = en_req_cnt;
    RST = 1'b1; RDY_requestEnq = 1'b1;
    #1;
    check("t6_en_in_rst", {31'b0, EN_request}, 32'd0);
    step();
    check_all_zero("t6_rst");
    RST = 1'b0;
    repeat (3) step();
    check("t6_no_en_after", en_req_cnt - base, 32'd0);
    check("t6_intr_masked", {31'b0, intr}, 32'd0);
    host_write(16'h0010, 32'h0BADBEEF);
    step();
    check("t6_new_en", {31'b0, EN_request}, 32'd1);
    check("t6_new_enq_v", requestEnqV, 32'h0BADBEEF);
    check("t6_new_count", en_req_cnt - base, 32'd0);
    step();
    check("t6_new_count_after", en_req_cnt - base, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
